// File: rtl/problem5.sv
// Registered 4:1 word multiplexer: i_ctrl picks one of four inputs, which is
// captured on the rising edge of i_clk and presented on o_data one clock later.
module problem5 #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data_0,
  input  logic [WIDTH-1:0] i_data_1,
  input  logic [WIDTH-1:0] i_data_2,
  input  logic [WIDTH-1:0] i_data_3,
  input  logic [1:0]       i_ctrl,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Every code is decoded, so there is no hold path and no invalid code.
  always_comb begin
    data_d = i_data_0;
    case (i_ctrl)
      2'b00:   data_d = i_data_0;
      2'b01:   data_d = i_data_1;
      2'b10:   data_d = i_data_2;
      2'b11:   data_d = i_data_3;
      default: data_d = i_data_0;
    endcase
  end

  // Reset wins over selection; the first edge after release loads normally.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_problem5.sv
// Bench for problem5: expected words are pushed at each rising edge from a
// reference model of the inputs, then popped and compared on the falling edge.
module tb_problem5;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] d0, d1, d2, d3;
  logic [1:0]   ctrl;
  logic [W-1:0] o_data;

  logic [W-1:0] exp_q[$];
  int           errors;
  int           checks;

  problem5 #(.WIDTH(W)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_data_0 (d0),
    .i_data_1 (d1),
    .i_data_2 (d2),
    .i_data_3 (d3),
    .i_ctrl   (ctrl),
    .o_data   (o_data)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: what the register must hold after an edge with these inputs.
  function automatic logic [W-1:0] model();
    logic [W-1:0] r;
    if (!rst_n) begin
      r = '0;
    end else begin
      case (ctrl)
        2'd0:    r = d0;
        2'd1:    r = d1;
        2'd2:    r = d2;
        default: r = d3;
      endcase
    end
    return r;
  endfunction

  // Driver: one clock; the expected value is captured at the edge itself.
  task automatic tick();
    @(posedge clk);
    exp_q.push_back(model());
    @(negedge clk);
  endtask

  task automatic set_patterns();
    d0 = 16'h0000;
    d1 = 16'h00ff;
    d2 = 16'hff00;
    d3 = 16'hffff;
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    rst_n = 1'b0;
    ctrl  = 2'b11;
    set_patterns();
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_data !== e || o_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, o_data, e);
      end
    end
    rst_n = 1'b1;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (o_data !== e || o_data !== 16'hffff) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", o_data, e);
    end
  endtask

  task automatic test_select();
    logic [W-1:0] e;
    logic [W-1:0] want [4];
    want[0] = 16'h0000; want[1] = 16'h00ff; want[2] = 16'hff00; want[3] = 16'hffff;
    for (int c = 0; c < 4; c++) begin
      ctrl = c[1:0];
      for (int k = 0; k < 3; k++) begin
        tick();
        e = exp_q.pop_front();
        checks++;
        if (o_data !== e || o_data !== want[c]) begin
          errors++;
          $display("FAIL select ctrl=%0d clk %0d: got %h expected %h", c, k, o_data, want[c]);
        end
      end
    end
  endtask

  task automatic test_latency();
    logic [W-1:0] e;
    ctrl = 2'b00;
    tick();
    e = exp_q.pop_front();
    checks++;
    if (o_data !== e) begin
      errors++;
      $display("FAIL latency_setup: got %h expected %h", o_data, e);
    end
    @(posedge clk);
    exp_q.push_back(model());
    #1;
    ctrl = 2'b10;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (o_data !== e || o_data !== 16'h0000) begin
      errors++;
      $display("FAIL latency_hold: got %h expected %h", o_data, e);
    end
    @(negedge clk);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (o_data !== e || o_data !== 16'hff00) begin
      errors++;
      $display("FAIL latency_update: got %h expected %h", o_data, e);
    end
  endtask

  task automatic test_unselected();
    logic [W-1:0] e;
    ctrl = 2'b01;
    tick();
    void'(exp_q.pop_front());
    d3 = 16'h1234;
    for (int k = 0; k < 2; k++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_data !== e || o_data !== 16'h00ff) begin
        errors++;
        $display("FAIL unselected clk %0d: got %h expected %h", k, o_data, e);
      end
    end
    d3 = 16'hffff;
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] e;
    ctrl = 2'b10;
    tick();
    void'(exp_q.pop_front());
    rst_n = 1'b0;
    #2;
    checks++;
    if (o_data !== 16'hff00) begin
      errors++;
      $display("FAIL reset_between_edges: got %h expected %h", o_data, 16'hff00);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (o_data !== e || o_data !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_zero: got %h expected %h", o_data, e);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_data !== e || o_data !== 16'hff00) begin
        errors++;
        $display("FAIL mid_reset_recover clk %0d: got %h expected %h", k, o_data, e);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] e;
    for (int i = 0; i < 1000; i++) begin
      ctrl  = 2'($urandom_range(0, 3));
      d0    = 16'($urandom_range(0, 16'hffff));
      d1    = 16'($urandom_range(0, 16'hffff));
      d2    = 16'($urandom_range(0, 16'hffff));
      d3    = 16'($urandom_range(0, 16'hffff));
      rst_n = ($urandom_range(0, 31) != 0);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (o_data !== e) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", i, o_data, e);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    ctrl   = 2'b00;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    @(negedge clk);
    test_reset();
    test_select();
    test_latency();
    test_unselected();
    test_mid_reset();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/problem5.md
PROBLEM5 -- requirements
Module: problem5

Interface
REQ-001 Parameter WIDTH, default 16: bit width of every data input and of o_data.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low; sampled only on the rising edge of i_clk.
REQ-004 i_data_0  input  WIDTH  candidate word 0, selected when i_ctrl = 2'b00.
REQ-005 i_data_1  input  WIDTH  candidate word 1, selected when i_ctrl = 2'b01.
REQ-006 i_data_2  input  WIDTH  candidate word 2, selected when i_ctrl = 2'b10.
REQ-007 i_data_3  input  WIDTH  candidate word 3, selected when i_ctrl = 2'b11.
REQ-008 i_ctrl  input  2  select code, unsigned.
REQ-009 o_data  output  WIDTH  registered selected word.
REQ-010 The block SHALL have one clock and a synchronous active-low reset (i_rst_n); it SHALL have no other control ports.

Function
REQ-011 The block SHALL be a 4:1 multiplexer with a registered output: o_data SHALL be driven directly by a WIDTH-bit flip-flop, with no combinational path from any input to o_data.
REQ-012 At each rising edge of i_clk with i_rst_n = 1, the output register SHALL load i_data_N, where N is the value of i_ctrl sampled at that edge.
REQ-013 Latency SHALL be exactly one clock: a change on i_ctrl or on the selected i_data_N SHALL appear on o_data after the next rising edge, not before.
REQ-014 A change on an unselected data input SHALL NOT affect o_data.
REQ-015 i_ctrl and data changes between rising edges SHALL have no effect; only the values present at the edge matter.
REQ-016 All four i_ctrl codes SHALL be decoded; there is no invalid code and no hold state.
REQ-017 The selection SHALL copy the word bit-for-bit, with no width change, sign extension or arithmetic.
REQ-018 If i_ctrl and the data inputs change at the same edge, the register SHALL load the value selected by the new i_ctrl from the new data, as sampled at that edge.

Reset
REQ-019 When i_rst_n = 0 at a rising edge of i_clk, o_data SHALL become all zeros ({WIDTH{1'b0}}) after that edge, regardless of i_ctrl and the data inputs.
REQ-020 Reset SHALL take priority over selection at every edge.
REQ-021 Asserting i_rst_n between edges SHALL NOT change o_data until the next rising edge.
REQ-022 On the first rising edge with i_rst_n = 1 after reset, o_data SHALL load the currently selected word; there SHALL be no extra recovery cycle.
REQ-023 Reset may be asserted at any time, including mid-sequence; the result SHALL be the same as at power-up.
REQ-024 Before the first reset edge, o_data is undefined; the bench SHALL NOT check it there.

Verification
REQ-025 Inputs i_data_0..3 = 16'h0000, 16'h00ff, 16'hff00, 16'hffff. Step i_ctrl 00, 01, 10, 11, holding each for several clocks -> one edge after each step, o_data = 16'h0000, 16'h00ff, 16'hff00, 16'hffff respectively.
REQ-026 Hold i_rst_n = 0 for 2 edges with i_ctrl = 11 -> o_data = 16'h0000. Release i_rst_n -> o_data = 16'hffff after the first edge.
REQ-027 Latency check: change i_ctrl from 00 to 10 just after an edge -> o_data stays 16'h0000 until the next edge, then becomes 16'hff00.
REQ-028 Unselected input: with i_ctrl = 01, change i_data_3 to 16'h1234 -> o_data stays 16'h00ff.
REQ-029 Mid-operation reset: with i_ctrl = 10, pulse i_rst_n low for 1 edge -> o_data = 16'h0000 for exactly one cycle, then 16'hff00.
REQ-030 Randomised: random i_ctrl and data for 1000 cycles -> o_data on every cycle equals the expected word computed from the previous edge's inputs.
